// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/align path.
`timescale 1ns/1ps
package fetch_pkg;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN
    } state_e;

    typedef logic [15:0] halfword_t;

    localparam logic [1:0]  OPC_QUAD_32 = 2'b11;
    localparam logic [31:0] PC_STEP_C   = 32'd2;
    localparam logic [31:0] PC_STEP_W   = 32'd4;

    function automatic logic hw_is_compressed(input halfword_t hw);
        return hw[1:0] != OPC_QUAD_32;
    endfunction

endpackage

// File: rtl/fetch_hw_buffer.sv
// Three-entry halfword shift register; entry 0 is the oldest halfword.
`timescale 1ns/1ps
module fetch_hw_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [1:0]  push_cnt,
    input  logic [15:0] push_lo,
    input  logic [15:0] push_hi,
    input  logic [1:0]  pop_cnt,
    output logic [15:0] hw0,
    output logic [15:0] hw1,
    output logic [1:0]  cnt
);

    halfword_t [2:0] buf_q, buf_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [1:0]      cnt_pop;

    // Pop happens before push so a full-rate stream never needs a fourth slot.
    always_comb begin
        buf_d = buf_q;
        case (pop_cnt)
            2'd1: begin
                buf_d[0] = buf_q[1];
                buf_d[1] = buf_q[2];
            end
            2'd2: buf_d[0] = buf_q[2];
            default: ;
        endcase
        cnt_pop = cnt_q - pop_cnt;
        for (int i = 0; i < 3; i++) begin
            if (push_cnt != 2'd0 && 2'(i) == cnt_pop) begin
                buf_d[i] = push_lo;
            end
            if (push_cnt == 2'd2 && 3'(i) == {1'b0, cnt_pop} + 3'd1) begin
                buf_d[i] = push_hi;
            end
        end
        cnt_d = flush ? 2'd0 : cnt_pop + push_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= 2'd0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign hw0 = buf_q[0];
    assign hw1 = buf_q[1];
    assign cnt = cnt_q;

endmodule

// File: rtl/fetch_align_unit.sv
// Fetches aligned words and presents a stream of 16/32-bit instructions with PC.
`timescale 1ns/1ps
module fetch_align_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_raw,
    output logic [31:0] instr_pc,
    output logic        instr_is_compressed
);

    localparam logic [31:0] RESET_PC_H = RESET_PC & 32'hFFFF_FFFE;
    localparam logic [31:0] RESET_FA   = RESET_PC & 32'hFFFF_FFFC;

    state_e      state_q;
    logic [31:0] fetch_addr_q;
    logic [31:0] pc_q;
    logic        skip_low_q;
    logic        req_q;

    logic [15:0] hw0, hw1;
    logic [1:0]  cnt;
    logic        hw0_c;
    logic        fire;
    logic        got_word;
    logic [1:0]  push_cnt;
    logic [1:0]  pop_cnt;
    logic [15:0] push_lo;

    always_comb begin
        hw0_c       = hw_is_compressed(hw0);
        instr_valid = (cnt >= 2'd1 && hw0_c) || (cnt >= 2'd2 && !hw0_c);
        fire        = instr_valid && instr_ready;
        pop_cnt     = fire ? (hw0_c ? 2'd1 : 2'd2) : 2'd0;
        // A response landing in a redirect cycle belongs to the old path.
        got_word    = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
        push_cnt    = got_word ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
        push_lo     = skip_low_q ? imem_rdata[31:16] : imem_rdata[15:0];
    end

    fetch_hw_buffer u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push_cnt (push_cnt),
        .push_lo  (push_lo),
        .push_hi  (imem_rdata[31:16]),
        .pop_cnt  (pop_cnt),
        .hw0      (hw0),
        .hw1      (hw1),
        .cnt      (cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            fetch_addr_q <= RESET_FA;
            pc_q         <= RESET_PC_H;
            skip_low_q   <= RESET_PC[1];
            req_q        <= 1'b0;
        end else begin
            req_q <= 1'b0;
            if (fire) begin
                pc_q <= pc_q + (hw0_c ? PC_STEP_C : PC_STEP_W);
            end
            if (redirect_valid) begin
                pc_q         <= redirect_pc & 32'hFFFF_FFFE;
                fetch_addr_q <= redirect_pc & 32'hFFFF_FFFC;
                skip_low_q   <= redirect_pc[1];
                // Still owed a response: swallow it before fetching the new path.
                if ((state_q == S_WAIT || state_q == S_DRAIN) && !imem_rvalid) begin
                    state_q <= S_DRAIN;
                end else begin
                    state_q <= S_FETCH;
                end
            end else begin
                case (state_q)
                    S_FETCH: begin
                        if (cnt <= 2'd1) begin
                            req_q   <= 1'b1;
                            state_q <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            fetch_addr_q <= fetch_addr_q + 32'd4;
                            skip_low_q   <= 1'b0;
                            state_q      <= S_FETCH;
                        end
                    end
                    S_DRAIN: begin
                        if (imem_rvalid) begin
                            state_q <= S_FETCH;
                        end
                    end
                    default: state_q <= S_FETCH;
                endcase
            end
        end
    end

    assign imem_req            = req_q;
    assign imem_addr           = fetch_addr_q;
    assign instr_pc            = pc_q;
    assign instr_is_compressed = hw0_c;
    assign instr_raw           = hw0_c ? {16'h0000, hw0} : {hw1, hw0};

endmodule
